jk_mod_counter: RTL and testbench
=================================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MOD, default 10: count modulus, 2 <= MOD <= 2**WIDTH.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 din  input  WIDTH  parallel load value.
REQ-009 q  output  WIDTH  registered count value.
REQ-010 tc  output  1  combinational terminal-count flag.
REQ-011 err  output  1  registered sticky out-of-range-load flag.

Function
REQ-012 Each bit of q SHALL be held in one JK stage driven from next-state n_i as J_i = n_i & ~q_i and K_i = ~n_i & q_i, so only changing bits see set, reset or toggle.
REQ-013 Priority per edge SHALL be load, then en, then hold.
REQ-014 load=1 with din < MOD: q <= din and err <= 0 on that edge.
REQ-015 load=1 with din >= MOD: q <= 0 and err <= 1 on that edge.
REQ-016 err SHALL stay set until reset or a valid load.
REQ-017 en=1, up=1, no load: q <= q+1, wrapping from MOD-1 to 0.
REQ-018 en=1, up=0, no load: q <= q-1, wrapping from 0 to MOD-1.
REQ-019 en=0, no load: q and err SHALL hold.
REQ-020 tc SHALL equal en & ~load & ((up & q==MOD-1) | (~up & q==0)), with zero latency, so it can chain into the next stage's en.
REQ-021 Direction changes SHALL take effect on the same edge, with no extra cycle.
REQ-022 Latency from load or en to q SHALL be one clock edge.
REQ-023 The counter SHALL stay in the range 0..MOD-1 after reset under all input sequences.

Reset
REQ-024 reset=1 SHALL force q=0 and err=0 immediately, independent of clk.
REQ-025 tc SHALL read 0 during reset.
REQ-026 A load or count in flight when reset asserts SHALL be discarded.
REQ-027 The first edge after reset deasserts SHALL act on the current inputs normally.

Configuration
REQ-028 Macro JK_CNT_PARITY_EN defined: add output par (1 bit), a register holding the even parity of q and updated on every edge where q changes.
REQ-029 par SHALL reset to 0 and SHALL equal ^q one cycle after each q update.
REQ-030 Macro JK_CNT_PARITY_EN undefined: no par port and no parity logic.

Structure
REQ-031 Package jk_cnt_pkg SHALL hold the JK control encodings JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10 and JK_TOG=2'b11, plus a typedef for the {j,k} pair.
REQ-032 One sub-module, jk_stage, SHALL be instantiated WIDTH times.
REQ-033 jk_stage ports: clk, reset (asynchronous, active-high), j, k, q; q resets to 0.
REQ-034 Next-state and J/K derivation SHALL be combinational logic inside jk_mod_counter.

Verification
REQ-035 Reset: assert reset mid-count at q=7 between edges -> q=0 and err=0 immediately; q stays 0 until the first edge after deassert.
REQ-036 Up wrap (MOD=10): en=1, up=1 from 0 for 12 edges -> q sequence 1..9,0,1,2; tc=1 only while q=9.
REQ-037 Down wrap: load din=2, then en=1, up=0 for 4 edges -> q sequence 1,0,9,8; tc=1 only while q=0.
REQ-038 Load priority and error: load=1, en=1, din=4'd12 -> q=0 and err=1; then load din=5 -> q=5 and err=0.
REQ-039 Hold and direction flip: at q=6, en=0 for 3 edges -> q=6; then en=1, toggle up each edge -> q sequence 7,6,7,6.
REQ-040 Parity (JK_CNT_PARITY_EN defined): count 0 to 3 -> par sequence 1,1,0 lagging q by one edge; build without the macro -> elaborates with no par port.

Source files
------------

// File: rtl/jk_cnt_pkg.sv
// Shared JK control encodings and the helper that derives a {j,k} pair for one counter bit.
package jk_cnt_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef struct packed {
        logic j;
        logic k;
    } jk_pair_t;

    // Only a bit that must change gets a set or reset drive; an unchanged bit holds.
    function automatic jk_pair_t jk_drive(input logic next_bit, input logic cur_bit);
        jk_pair_t p;
        p.j = next_bit & ~cur_bit;
        p.k = ~next_bit & cur_bit;
        return p;
    endfunction

endpackage

// File: rtl/jk_stage.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
module jk_stage
    import jk_cnt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MOD counter built from JK stages, with parallel load and sticky range error.
// Optional registered parity output `par` when JK_CNT_PARITY_EN is defined.
module jk_mod_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             err
`ifdef JK_CNT_PARITY_EN
    ,
    output logic             par
`endif
);

    // One extra bit so MOD == 2**WIDTH is representable in the range compare.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] next_q;
    logic             next_err;
    jk_pair_t         jk [WIDTH];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_q   = q;
        next_err = err;
        if (load) begin
            if ({1'b0, din} < MOD_X) begin
                next_q   = din;
                next_err = 1'b0;
            end else begin
                next_q   = '0;
                next_err = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                next_q = (q == MAX_Q) ? '0 : q + WIDTH'(1);
            end else begin
                next_q = (q == '0) ? MAX_Q : q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            jk[i] = jk_drive(next_q[i], q[i]);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_stage u_stage (
            .clk   (clk),
            .reset (reset),
            .j     (jk[i].j),
            .k     (jk[i].k),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= next_err;
        end
    end

    // Gated by reset so a held-low counter with en & ~up does not flag terminal count.
    assign tc = ~reset & en & ~load & ((up & (q == MAX_Q)) | (~up & (q == '0)));

`ifdef JK_CNT_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par <= 1'b0;
        end else begin
            par <= ^q;
        end
    end
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed scenarios plus random stimulus against a model.
`timescale 1ns/1ps
module tb_jk_mod_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             err;
`ifdef JK_CNT_PARITY_EN
    logic             par;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: plain integers, updated with modular arithmetic.
    int m_q   = 0;
    int m_err = 0;
    int m_par = 0;

    jk_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .up    (up),
        .load  (load),
        .din   (din),
        .q     (q),
        .tc    (tc),
        .err   (err)
`ifdef JK_CNT_PARITY_EN
        ,
        .par   (par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_tc(input logic l, input logic e, input logic u);
        if (!e || l) return 0;
        if (u) return (m_q == MOD - 1) ? 1 : 0;
        return (m_q == 0) ? 1 : 0;
    endfunction

    function automatic int odd_parity(input int v);
        return $countones(v) % 2;
    endfunction

    task automatic model_edge(input logic l, input logic e, input logic u, input int d);
        m_par = odd_parity(m_q);
        if (l) begin
            if (d < MOD) begin
                m_q = d; m_err = 0;
            end else begin
                m_q = 0; m_err = 1;
            end
        end else if (e) begin
            m_q = u ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".q"}, 32'(q), 32'(m_q));
        check({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef JK_CNT_PARITY_EN
        check({tag, ".par"}, 32'(par), 32'(m_par));
`endif
    endtask

    // Called just after a falling edge: apply inputs, check tc, clock once, check state.
    task automatic step(input logic l, input logic e, input logic u, input int d, input string tag);
        load = l; en = e; up = u; din = WIDTH'(d);
        #1;
        check({tag, ".tc"}, 32'(tc), 32'(model_tc(l, e, u)));
        @(posedge clk);
        model_edge(l, e, u, d);
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; din = '0;
        @(negedge clk);
        @(negedge clk);
        check("por.q", 32'(q), 0);
        check("por.err", 32'(err), 0);
        check("por.tc", 32'(tc), 0);
        reset = 1'b0;

        // Up wrap through MOD-1.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 0, "upwrap");

        // Down wrap through 0.
        step(1'b1, 1'b0, 1'b0, 2, "dnload");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0, "dnwrap");

        // Load beats enable; out-of-range load sets err, valid load clears it.
        step(1'b1, 1'b1, 1'b1, 12, "loaderr");
        step(1'b0, 1'b1, 1'b1, 0, "errsticky");
        step(1'b1, 1'b1, 1'b0, 5, "loadok");
        step(1'b1, 1'b0, 1'b0, 10, "loadmod");
        step(1'b1, 1'b0, 1'b0, 9, "loadmax");

        // Hold, then flip direction every edge.
        step(1'b1, 1'b0, 1'b0, 6, "load6");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 0, "hold");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i % 2) == 0, 0, "flip");

        // Parity from 0 up to 3.
        step(1'b1, 1'b0, 1'b1, 0, "parload");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 0, "parcount");

        // Asynchronous reset mid-count with err set and a load pending.
        step(1'b1, 1'b0, 1'b1, 15, "preerr");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 0, "to7");
        check("at7.q", 32'(q), 7);
        en = 1'b1; up = 1'b0; load = 1'b0;
        #2 reset = 1'b1;
        #1;
        m_q = 0; m_err = 0; m_par = 0;
        check("arst.q", 32'(q), 0);
        check("arst.err", 32'(err), 0);
        check("arst.tc", 32'(tc), 0);
        load = 1'b1; din = 4'd5;
        @(posedge clk);
        #1;
        check_state("inrst");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 5, "postrst");

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), "rand");
            check("rand.range", 32'(q < MOD), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
